// File: rtl/seg_pkg.sv
// seg_pkg: shared digit count, hex font and scan phase type for the seven-segment scanner
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic {PH_BLANK, PH_SHOW} phase_e;
endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// hex7seg: combinational nibble to seven-segment decoder
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_FONT[nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed display scanner with frame-aligned updates and blanking
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 125000,
  parameter int BLANK_CYCLES = 1250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        lzb,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  logic [CW-1:0] slot_cnt, slot_nxt;
  logic [DW-1:0] digit, digit_nxt;
  logic [15:0] shadow, active;
  logic slot_end, boundary, lz, lit;
  logic [6:0] font, seg_d;
  logic [3:0] an_d;
  phase_e phase;
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      digit    <= '0;
      shadow   <= '0;
      active   <= '0;
      seg      <= '0;
      an       <= '0;
    end else begin
      slot_cnt <= slot_nxt;
      digit    <= digit_nxt;
      if (wr_en) shadow <= wr_data;
      if (boundary) active <= shadow;
      seg      <= seg_d;
      an       <= an_d;
    end
  end
  always_comb begin
    slot_end  = slot_cnt == CW'(CLK_DIV - 1);
    boundary  = slot_end && digit == DW'(NUM_DIGITS - 1);
    slot_nxt  = slot_end ? '0 : slot_cnt + CW'(1);
    digit_nxt = slot_end ? digit + DW'(1) : digit;
    phase     = slot_cnt < CW'(BLANK_CYCLES) ? PH_BLANK : PH_SHOW;
  end
  hex7seg u_font (.nib(active[{digit, 2'b00} +: 4]), .seg(font));
  // a digit is a leading zero when it and every more significant nibble are zero
  always_comb begin
    lz    = lzb && digit != '0 && (active >> {digit, 2'b00}) == '0;
    lit   = phase == PH_SHOW && !lz;
    an_d  = lit ? 4'b0001 << digit : '0;
    seg_d = lit ? font : '0;
  end
  assign frame_done = boundary && !rst;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: frame-by-frame directed vectors plus reset and write-timing corner cases
module tb_seg_scan_ctrl;
  typedef struct {
    int          w1;
    logic [15:0] v1;
    int          w2;
    logic [15:0] v2;
    logic        lz;
    logic [3:0][6:0] s;
    logic [3:0]  en;
  } vec_t;
  localparam logic [27:0] ZERO = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
  logic clk = 1'b0, rst, wr_en, lzb;
  logic [15:0] wr_data;
  logic [6:0] seg;
  logic [3:0] an;
  logic frame_done;
  int n_cmp = 0, n_bad = 0;
  vec_t tv [12];
  seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .lzb(lzb),
    .seg(seg), .an(an), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  // called just after the negedge of a frame's cycle 0; returns after the next frame's cycle 0
  task automatic run_frame(input vec_t v);
    lzb = v.lz;
    for (int j = 1; j <= 32; j++) begin
      int k, d, p;
      logic show;
      @(negedge clk);
      k = j - 1;
      d = k / 8;
      p = k % 8;
      show = p >= 2 && v.en[d];
      chk("an", 8'(an), show ? 8'(4'b0001 << d) : 8'h00);
      chk("seg", 8'(seg), show ? 8'(v.s[d]) : 8'h00);
      chk("frame_done", 8'(frame_done), 8'(j == 31));
      wr_en = j == v.w1 || j == v.w2;
      wr_data = j == v.w2 ? v.v2 : v.v1;
    end
  endtask
  always @(negedge clk) if (!rst) begin
    n_cmp++;
    if (!$onehot0(an)) begin
      n_bad++;
      $display("FAIL an_onehot at %0t: got %b expected one-hot or zero", $time, an);
    end
  end
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; lzb = 1'b0;
    tv[0]  = '{0,  16'h0,    0,  16'h0,    1'b0, ZERO, 4'hF};
    tv[1]  = '{10, 16'h1234, 0,  16'h0,    1'b0, ZERO, 4'hF};
    tv[2]  = '{0,  16'h0,    0,  16'h0,    1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'hF};
    tv[3]  = '{5,  16'hAAAA, 20, 16'hBEEF, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'hF};
    tv[4]  = '{31, 16'h5555, 0,  16'h0,    1'b0, {7'h7C, 7'h79, 7'h79, 7'h71}, 4'hF};
    tv[5]  = '{0,  16'h0,    0,  16'h0,    1'b0, {7'h7C, 7'h79, 7'h79, 7'h71}, 4'hF};
    tv[6]  = '{3,  16'h0070, 0,  16'h0,    1'b1, {7'h6D, 7'h6D, 7'h6D, 7'h6D}, 4'hF};
    tv[7]  = '{0,  16'h0,    0,  16'h0,    1'b1, {7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'h3};
    tv[8]  = '{3,  16'h0000, 0,  16'h0,    1'b1, {7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'h3};
    tv[9]  = '{0,  16'h0,    0,  16'h0,    1'b1, ZERO, 4'h1};
    tv[10] = '{5,  16'h0042, 0,  16'h0,    1'b0, ZERO, 4'hF};
    tv[11] = '{0,  16'h0,    0,  16'h0,    1'b0, {7'h3F, 7'h3F, 7'h66, 7'h5B}, 4'hF};
    repeat (3) @(negedge clk);
    chk("rst_an", 8'(an), 8'h00);
    chk("rst_seg", 8'(seg), 8'h00);
    chk("rst_frame_done", 8'(frame_done), 8'h00);
    rst = 1'b0;
    foreach (tv[i]) run_frame(tv[i]);
    // pending write of 0xFFFF must be lost when reset hits during digit 2
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      wr_en = j == 3;
      wr_data = 16'hFFFF;
    end
    chk("pre_rst_an", 8'(an), 8'h04);
    chk("pre_rst_seg", 8'(seg), 8'h3F);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", 8'(an), 8'h00);
    chk("mid_rst_seg", 8'(seg), 8'h00);
    chk("mid_rst_frame_done", 8'(frame_done), 8'h00);
    rst = 1'b0;
    run_frame('{0, 16'h0, 0, 16'h0, 1'b0, ZERO, 4'hF});
    run_frame('{0, 16'h0, 0, 16'h0, 1'b0, ZERO, 4'hF});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
